// File: rtl/vctr_op_pkg.sv
// Shared types and the element-wise operation for vctr_fifo_op.
// Operands are evaluated in a fixed wide word and callers truncate to their result width.
package vctr_op_pkg;

    // Wide enough for any DATA_WIDTH <= 31 and OUT_WIDTH <= 64.
    localparam int unsigned OP_WIDTH_MAX = 64;

    typedef logic [OP_WIDTH_MAX-1:0] op_word_t;

    typedef enum logic [1:0] {
        OP_ADD      = 2'd0,
        OP_SUB      = 2'd1,
        OP_ABS_DIFF = 2'd2,
        OP_SQ_DIFF  = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StCompute,
        StDrain
    } state_t;

    // a and b arrive zero-extended, so the wide difference is already sign-extended and
    // truncating the return value to OUT_WIDTH yields the exact result for every op.
    function automatic op_word_t vctr_op_apply(input op_word_t a, input op_word_t b,
                                               input op_t op);
        op_word_t diff;
        op_word_t mag;
        op_word_t res;
        diff = a - b;
        mag  = diff[OP_WIDTH_MAX-1] ? (~diff + 1'b1) : diff;
        case (op)
            OP_ADD:      res = a + b;
            OP_SUB:      res = diff;
            OP_ABS_DIFF: res = mag;
            OP_SQ_DIFF:  res = mag * mag;
            default:     res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/vctr_fifo_op_fifo.sv
// Synchronous FIFO with registered occupancy count; full/empty are derived by the user.
// Push when full and pop when empty are ignored.
module vctr_fifo_op_fifo #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              push_i,
    input  logic [DATA_WIDTH-1:0]             wdata_i,
    input  logic                              pop_i,
    output logic [DATA_WIDTH-1:0]             rdata_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(FIFO_DEPTH - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  push_en, pop_en;

    assign push_en = push_i && (count_q != FullCnt);
    assign pop_en  = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_en) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the count gates every read.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/vctr_fifo_op.sv
// Two-operand vector FIFO engine: load A then B, apply the latched op element-wise, drain results.
// Optional running-sum output acc_out is enabled by defining VCTR_FIFO_OP_ACC_EN.
module vctr_fifo_op
    import vctr_op_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned VECTOR_LENGTH = 8,
    parameter int unsigned OUT_WIDTH     = 2 * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  data_out_valid,
    input  logic                  data_out_ready,
    output logic [OUT_WIDTH-1:0]  data_out,
    output logic                  idle,
    output logic                  busy,
    output logic                  done
`ifdef VCTR_FIFO_OP_ACC_EN
    ,
    output logic [OUT_WIDTH+$clog2(VECTOR_LENGTH):0] acc_out
`endif
);

    localparam int unsigned CntW = $clog2(VECTOR_LENGTH + 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(VECTOR_LENGTH);
    localparam logic [CntW-1:0] OneCnt  = CntW'(1);

    state_t                state_q, state_d;
    op_t                   mode_q;
    logic                  idle_q, busy_q, done_q;

    logic [CntW-1:0]       a_cnt, b_cnt, o_cnt;
    logic [DATA_WIDTH-1:0] a_rdata, b_rdata;
    logic [OUT_WIDTH-1:0]  o_rdata;
    logic                  a_full, a_empty, b_full, b_empty, o_empty;
    logic                  a_push, b_push, pop_ab, o_pop;
    logic                  start_acc, drain_last, pipe_empty;

    logic                  s1_v_q, s2_v_q;
    logic [DATA_WIDTH-1:0] s1_a_q, s1_b_q;
    logic [OUT_WIDTH-1:0]  s1_res, s2_res_q;

    assign a_full  = (a_cnt == FullCnt);
    assign a_empty = (a_cnt == '0);
    assign b_full  = (b_cnt == FullCnt);
    assign b_empty = (b_cnt == '0);
    assign o_empty = (o_cnt == '0);

    assign data_in_ready = ((state_q == StLoadA) && !a_full) ||
                           ((state_q == StLoadB) && !b_full);
    assign a_push = data_in_valid && data_in_ready && (state_q == StLoadA);
    assign b_push = data_in_valid && data_in_ready && (state_q == StLoadB);

    assign pop_ab     = (state_q == StCompute) && !a_empty && !b_empty;
    assign pipe_empty = a_empty && b_empty && !s1_v_q && !s2_v_q;

    assign data_out_valid = !o_empty && (state_q == StDrain);
    assign o_pop          = data_out_valid && data_out_ready;
    assign data_out       = data_out_valid ? o_rdata : '0;

    assign start_acc  = (state_q == StIdle) && start;
    // Leave DRAIN on the handshake that empties the output FIFO.
    assign drain_last = o_pop && (o_cnt == OneCnt);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (start)                   state_d = StLoadA;
            StLoadA:   if (a_full)                  state_d = StLoadB;
            StLoadB:   if (b_full)                  state_d = StCompute;
            StCompute: if (pipe_empty)              state_d = StDrain;
            StDrain:   if (o_empty || drain_last)   state_d = StIdle;
            default:                                state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            mode_q  <= OP_ADD;
            idle_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idle_q  <= (state_d == StIdle);
            busy_q  <= (state_d == StLoadA) || (state_d == StLoadB) || (state_d == StCompute);
            done_q  <= (state_d == StDrain);
            if (start_acc) begin
                mode_q <= op_t'(mode);
            end
        end
    end

    assign idle = idle_q;
    assign busy = busy_q;
    assign done = done_q;

    assign s1_res = OUT_WIDTH'(vctr_op_apply(op_word_t'(s1_a_q), op_word_t'(s1_b_q), mode_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q   <= 1'b0;
            s2_v_q   <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s2_res_q <= '0;
        end else begin
            s1_v_q <= pop_ab;
            s2_v_q <= s1_v_q;
            if (pop_ab) begin
                s1_a_q <= a_rdata;
                s1_b_q <= b_rdata;
            end
            if (s1_v_q) begin
                s2_res_q <= s1_res;
            end
        end
    end

    vctr_fifo_op_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (VECTOR_LENGTH)
    ) u_fifo_a (
        .clk     (clk),
        .rst     (rst),
        .push_i  (a_push),
        .wdata_i (data_in),
        .pop_i   (pop_ab),
        .rdata_o (a_rdata),
        .count_o (a_cnt)
    );

    vctr_fifo_op_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (VECTOR_LENGTH)
    ) u_fifo_b (
        .clk     (clk),
        .rst     (rst),
        .push_i  (b_push),
        .wdata_i (data_in),
        .pop_i   (pop_ab),
        .rdata_o (b_rdata),
        .count_o (b_cnt)
    );

    vctr_fifo_op_fifo #(
        .DATA_WIDTH (OUT_WIDTH),
        .FIFO_DEPTH (VECTOR_LENGTH)
    ) u_fifo_out (
        .clk     (clk),
        .rst     (rst),
        .push_i  (s2_v_q),
        .wdata_i (s2_res_q),
        .pop_i   (o_pop),
        .rdata_o (o_rdata),
        .count_o (o_cnt)
    );

`ifdef VCTR_FIFO_OP_ACC_EN
    localparam int unsigned AccW = OUT_WIDTH + $clog2(VECTOR_LENGTH) + 1;

    logic [AccW-1:0] acc_q, acc_add;

    // SUB results are two's complement and must keep their sign in the wider sum.
    assign acc_add = (mode_q == OP_SUB) ? AccW'($signed(s2_res_q)) : AccW'(s2_res_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (start_acc) begin
            acc_q <= '0;
        end else if (s2_v_q) begin
            acc_q <= acc_q + acc_add;
        end
    end

    assign acc_out = acc_q;
`endif

endmodule
